// File: rtl/model_fetch_ctrl.sv
// Read-side fetch controller: walks a byte range of the model store and streams little-endian packed words.
// Optional MODEL_FETCH_CHECKSUM_EN adds chk_sum, a mod-256 sum of the bytes fetched by the current job.
module model_fetch_ctrl #(
    parameter int ADDR_W = 21,
    parameter int BPW    = 4,
    parameter int LEN_W  = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    byte_len,
    output logic [ADDR_W-1:0]   fram_addr,
    output logic                fram_wren,
    input  logic [7:0]          fram_dataout,
    output logic [8*BPW-1:0]    word_data,
    output logic                word_valid,
    output logic                word_last,
    input  logic                word_ready,
    output logic                busy,
    output logic                done
`ifdef MODEL_FETCH_CHECKSUM_EN
    ,
    output logic [7:0]          chk_sum
`endif
);

    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic [ADDR_W-1:0]  ptr_q,        ptr_d;
    logic [LEN_W-1:0]   remain_q,     remain_d;
    logic [LANE_W-1:0]  lane_q,       lane_d;
    logic [8*BPW-1:0]   acc_q,        acc_d;
    logic [8*BPW-1:0]   word_data_q,  word_data_d;
    logic               word_valid_q, word_valid_d;
    logic               word_last_q,  word_last_d;

    logic               last_byte;
    logic               word_end;
    logic               capture;
    logic               accept;
    logic [8*BPW-1:0]   merged;

    assign last_byte = (remain_q == LEN_W'(1));
    assign word_end  = (lane_q == LANE_W'(BPW - 1)) || last_byte;
    assign accept    = word_valid_q && word_ready;
    // Only a word-completing byte needs the output slot; partial lanes keep streaming during a stall.
    assign capture   = (state_q == S_FETCH) && (!word_end || !word_valid_q || word_ready);

    // Lanes above the current one are always zero in acc_q, which pads short final words.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (lane_q == LANE_W'(gi)) ? fram_dataout : acc_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;

        if (accept) begin
            word_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d    = base_addr;
                    remain_d = byte_len;
                    lane_d   = '0;
                    acc_d    = '0;
                    state_d  = (byte_len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (capture) begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (word_end) begin
                        acc_d        = '0;
                        lane_d       = '0;
                        word_data_d  = merged;
                        word_valid_d = 1'b1;
                        word_last_d  = last_byte;
                    end else begin
                        acc_d  = merged;
                        lane_d = lane_q + LANE_W'(1);
                    end
                    if (last_byte) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            lane_q       <= '0;
            acc_q        <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
        end
    end

`ifdef MODEL_FETCH_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == S_IDLE && start) begin
            chk_d = 8'h00;
        end else if (capture) begin
            chk_d = chk_q + fram_dataout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_sum = chk_q;
`endif

    assign fram_addr  = ptr_q;
    assign fram_wren  = 1'b0;
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
